// File: rtl/wb_write_queue.sv
//==============================================================================
// Module  : wb_write_queue
// Brief   : Register-file write-port arbiter: ALU writeback, buffered
//           long-latency results and a pending-write scoreboard.
// Revision: 1.0
//==============================================================================
`default_nettype none

module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_we,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_wd,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rd,
    output logic          iss_ready,
    input  logic          res_valid,
    input  logic [4:0]    res_rd,
    input  logic [31:0]   res_data,
    output logic          res_ready,
    input  logic [4:0]    q_a1,
    input  logic [4:0]    q_a2,
    output logic          busy1,
    output logic          busy2,
    output logic          we3,
    output logic [4:0]    a3,
    output logic [31:0]   wd3,
    output logic [CW-1:0] count
);

    localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [4:0]    r_fifo_rd [DEPTH];
    logic [31:0]   r_fifo_wd [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_busy;
    logic          r_we3;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd3;

    logic          w_res_acc;
    logic          w_res_nz;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic          w_iss_fire;
    logic          w_clr;
    logic [4:0]    w_clr_rd;
    logic [31:0]   w_busy_nxt;

    assign res_ready  = (r_count != C_FULL);
    assign iss_ready  = ~r_busy[iss_rd];
    assign busy1      = r_busy[q_a1] & (q_a1 != 5'd0);
    assign busy2      = r_busy[q_a2] & (q_a2 != 5'd0);
    assign we3        = r_we3;
    assign a3         = r_a3;
    assign wd3        = r_wd3;
    assign count      = r_count;

    // ALU writeback has absolute priority; the FIFO drains only on idle ALU cycles,
    // and a fresh result skips the FIFO only when nothing older is waiting.
    assign w_res_acc  = res_valid & res_ready;
    assign w_res_nz   = w_res_acc & (res_rd != 5'd0);
    assign w_pop      = ~alu_we & (r_count != '0);
    assign w_bypass   = ~alu_we & (r_count == '0) & w_res_nz;
    assign w_push     = w_res_nz & ~w_bypass;
    assign w_iss_fire = iss_valid & iss_ready & (iss_rd != 5'd0);
    assign w_clr      = w_pop | w_bypass;
    assign w_clr_rd   = w_pop ? r_fifo_rd[r_rd_ptr] : res_rd;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[w_clr_rd] = 1'b0;
        end
        if (w_iss_fire) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr] <= res_rd;
            r_fifo_wd[r_wr_ptr] <= res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (alu_we) begin
            r_we3 <= (alu_rd != 5'd0);
            r_a3  <= alu_rd;
            r_wd3 <= alu_wd;
        end else if (w_pop) begin
            r_we3 <= 1'b1;
            r_a3  <= r_fifo_rd[r_rd_ptr];
            r_wd3 <= r_fifo_wd[r_rd_ptr];
        end else if (w_bypass) begin
            r_we3 <= 1'b1;
            r_a3  <= res_rd;
            r_wd3 <= res_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

endmodule

`default_nettype wire
